mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Variable-latency memory access sequencer between the multi-cycle control unit and the shared instruction/data memory bus. It converts the controller's single-cycle read/write strobes into a req/ack bus transaction. While the transaction is outstanding, it holds the controller with a stall signal. It latches read data for the instruction and data registers, and reports misaligned or timed-out accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles without ack before an error; range 1..255
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_i  in  1  read strobe from controller
- wr_i  in  1  write strobe from controller
- addr_i  in  ADDR_W  byte address (PC or ALU result, already muxed)
- wdata_i  in  DATA_W  store data
- rdata_o  out  DATA_W  last completed read data, registered
- stall_o  out  1  controller must hold its state while high
- err_o  out  1  sticky error flag
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1 = write, registered
- bus_addr_o  out  ADDR_W  registered address
- bus_wdata_o  out  DATA_W  registered write data
- bus_ack_i  in  1  bus completion
- bus_rdata_i  in  DATA_W  read data, valid with bus_ack_i

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE:** when rd_i or wr_i is high, capture addr_i, wdata_i and we = wr_i into the bus registers, then go to WAIT.
  - rd_i and wr_i both high: write wins.
  - Misaligned access (addr_i[1:0] != 0): no bus request, err_o set, go to DONE.
- **WAIT:** bus_req_o is high and the timeout counter increments each cycle.
  - On bus_ack_i: for reads, rdata_o <= bus_rdata_i. bus_req_o drops, go to DONE.
  - Counter reaches TIMEOUT with no ack: bus_req_o drops, err_o set, rdata_o unchanged, go to DONE.
- **DONE:** one cycle, stall_o low, then return to IDLE unconditionally. Strobes seen during DONE are ignored; a new access starts only from IDLE.
- err_o is sticky and clears only on rst.
- Writes never modify rdata_o.
- bus_ack_i outside WAIT is ignored.

## Timing
- Reset values: state IDLE; bus_req_o, bus_we_o, stall_o, err_o = 0; bus_addr_o, bus_wdata_o, rdata_o, counter = 0.
- stall_o = (IDLE & (rd_i | wr_i)) | WAIT. It is combinational from the strobes in IDLE, so the controller sees the stall in the same cycle it issues the strobe.
- bus_req_o first goes high in the cycle after the strobe (first WAIT cycle).
- Minimum latency with an ack in the first WAIT cycle:
  - Strobe in cycle 0 (IDLE), WAIT in cycle 1.
  - rdata_o valid and stall_o low in cycle 2 (DONE).
  - This gives 2 stalled cycles.
- Ack after k WAIT cycles gives k+1 stalled cycles.
- bus_addr_o, bus_we_o and bus_wdata_o stay stable for the whole of WAIT.
- Timeout: stall_o is high for TIMEOUT+1 cycles, then DONE with err_o high.
- Reset mid-transaction: bus_req_o and stall_o drop asynchronously and the state goes to IDLE. An ack arriving after reset is ignored.

## Structure
- Shared package mem_pkg holds:
  - mem_state_t enum {IDLE, WAIT, DONE}
  - constant ALIGN_MASK = 2'b11
- Sub-module mem_timeout_ctr:
  - 8-bit counter with clear and enable inputs and an expired output.
  - Cleared on entry to WAIT, enabled during WAIT.

## Test plan
- Read at 0x00000010, ack in the first WAIT cycle with 0x8C010004 -> stall_o high for 2 cycles, rdata_o = 0x8C010004 in DONE, err_o = 0.
- Write 0xCAFEF00D to 0x00000020, ack after 5 cycles -> bus_we_o = 1, bus_addr/wdata stable for 5 cycles, stall high for 6 cycles, rdata_o unchanged.
- Read at 0x00000013 -> no bus_req_o, err_o = 1 from DONE onward, stall_o high for 1 cycle.
- Read with no ack, TIMEOUT = 4 -> stall_o high for 5 cycles, bus_req_o drops, err_o = 1 and held through later good accesses.
- rd_i and wr_i both high at 0x40 -> write transaction issued; stray bus_ack_i pulses in IDLE and DONE cause no state change.
- rst pulsed in the 3rd WAIT cycle -> all outputs return to 0 immediately; a following read completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory access sequencer.
//   mem_state_t   : sequencer state encoding (IDLE / WAIT / DONE)
//   ALIGN_MASK    : byte-offset bits that must be zero for a word access
//   is_misaligned : true when the low address bits select a non-word offset
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Request/acknowledge bus between the access sequencer (master) and the
// shared instruction/data memory (slave).
//   bus_req_o   : master -> slave, transaction outstanding
//   bus_we_o    : master -> slave, 1 = write
//   bus_addr_o  : master -> slave, byte address
//   bus_wdata_o : master -> slave, store data
//   bus_ack_i   : slave -> master, transaction complete
//   bus_rdata_i : slave -> master, read data, valid with bus_ack_i
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_wdata_o,
    input  bus_ack_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_wdata_o,
    output bus_ack_i,
    output bus_rdata_i
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// 8-bit up-counter measuring how long a bus transaction has been waiting.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart from zero (asserted on the edge that enters WAIT)
//   en       : count this cycle (high for every WAIT cycle)
//   expired  : the current WAIT cycle is the LIMIT-th one without an ack
// ---------------------------------------------------------------------------
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count is zero during the first WAIT cycle, so the LIMIT-th cycle
  // is the one where the count equals LIMIT-1.
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Turns the multi-cycle controller's single-cycle read/write strobes into a
// req/ack bus transaction, stalling the controller until it completes.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   rd_i, wr_i  : access strobes from the controller (write wins if both)
//   addr_i      : byte address (PC or ALU result)
//   wdata_i     : store data
//   rdata_o     : last completed read data (registered)
//   stall_o     : controller must hold while high
//   err_o       : sticky error (misaligned access or bus timeout)
//   bus         : master side of the memory bus interface
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | no access outstanding; a strobe starts one (stall is comb.)
// WAIT  | bus_req_o high, waiting for bus_ack_i or the timeout
// DONE  | single completion cycle, stall low, strobes ignored
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o,
  mem_access_unit_if.master bus
);

  mem_state_t state;
  mem_state_t next_state;

  logic strobe;
  logic misaligned;
  logic start;
  logic err_set;
  logic rd_done;
  logic ctr_clr;
  logic ctr_en;
  logic tmo_expired;

  assign strobe     = rd_i | wr_i;
  assign misaligned = is_misaligned(addr_i[1:0]);

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. An ack in the same cycle as expiry still completes
  // the access normally.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (strobe) begin
          next_state = misaligned ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.bus_ack_i || tmo_expired) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    stall_o = 1'b0;
    start   = 1'b0;
    err_set = 1'b0;
    rd_done = 1'b0;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    case (state)
      IDLE: begin
        stall_o = strobe;
        start   = strobe && !misaligned;
        err_set = strobe && misaligned;
        ctr_clr = strobe && !misaligned;
      end
      WAIT: begin
        stall_o = 1'b1;
        ctr_en  = 1'b1;
        rd_done = bus.bus_ack_i && !bus.bus_we_o;
        err_set = !bus.bus_ack_i && tmo_expired;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  // Bus registers and result latches. bus_req_o follows the registered
  // state so it is high exactly for the WAIT cycles and drops with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_wdata_o <= '0;
      rdata_o         <= '0;
      err_o           <= 1'b0;
    end else begin
      bus.bus_req_o <= (next_state == WAIT);
      if (start) begin
        bus.bus_we_o    <= wr_i;
        bus.bus_addr_o  <= addr_i;
        bus.bus_wdata_o <= wdata_i;
      end
      if (rd_done) begin
        rdata_o <= bus.bus_rdata_i;
      end
      if (err_set) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Two instances: index 0 with a long timeout for the normal-access cases,
// index 1 with TIMEOUT = 4 for the timeout cases. Stimulus pushes the
// expected outcome of each access; a per-instance monitor measures each
// access (stall length, request length, bus stability) and compares it
// against the queue in the completion cycle.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  typedef struct {
    int          stall_n;
    int          req_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  logic        rd     [2];
  logic        wr     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ack    [2];
  logic [31:0] brdata [2];

  logic [1:0]  stall_v;
  logic [1:0]  err_v;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] rdata_a  [2];
  logic [31:0] baddr_a  [2];
  logic [31:0] bwdata_a [2];

  exp_t exp_q [2][$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int TO = (g == 0) ? 16 : 4;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic [31:0] rdata_w;
    logic        stall_w;
    logic        err_w;

    assign bus.bus_ack_i   = ack[g];
    assign bus.bus_rdata_i = brdata[g];

    mem_access_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .rd_i    (rd[g]),
      .wr_i    (wr[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .rdata_o (rdata_w),
      .stall_o (stall_w),
      .err_o   (err_w),
      .bus     (bus)
    );

    assign stall_v[g]  = stall_w;
    assign err_v[g]    = err_w;
    assign req_v[g]    = bus.bus_req_o;
    assign we_v[g]     = bus.bus_we_o;
    assign rdata_a[g]  = rdata_w;
    assign baddr_a[g]  = bus.bus_addr_o;
    assign bwdata_a[g] = bus.bus_wdata_o;

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        prev_st  = 1'b0;
    int          stall_n  = 0;
    int          req_n    = 0;
    logic        unstable = 1'b0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wd;
    exp_t        e;

    always @(negedge clk) begin
      if (stall_w) begin
        stall_n++;
        if (bus.bus_req_o) begin
          if (req_n == 0) begin
            cap_we   = bus.bus_we_o;
            cap_addr = bus.bus_addr_o;
            cap_wd   = bus.bus_wdata_o;
          end else if (bus.bus_we_o !== cap_we || bus.bus_addr_o !== cap_addr ||
                       bus.bus_wdata_o !== cap_wd) begin
            unstable = 1'b1;
          end
          req_n++;
        end
      end else if (prev_st) begin
        if (exp_q[g].size() == 0) begin
          chk($sformatf("dut%0d unexpected_access", g), 32'd1, 32'd0);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("dut%0d stall_cycles", g), 32'(stall_n), 32'(e.stall_n));
          chk($sformatf("dut%0d req_cycles", g), 32'(req_n), 32'(e.req_n));
          chk($sformatf("dut%0d rdata", g), rdata_w, e.rdata);
          chk($sformatf("dut%0d err", g), {31'd0, err_w}, {31'd0, e.err});
          chk($sformatf("dut%0d req_low_in_done", g), {31'd0, bus.bus_req_o}, 32'd0);
          if (e.req_n > 0) begin
            chk($sformatf("dut%0d bus_we", g), {31'd0, cap_we}, {31'd0, e.we});
            chk($sformatf("dut%0d bus_addr", g), cap_addr, e.addr);
            chk($sformatf("dut%0d bus_wdata", g), cap_wd, e.wdata);
            chk($sformatf("dut%0d bus_stable", g), {31'd0, unstable}, 32'd0);
          end
        end
        stall_n  = 0;
        req_n    = 0;
        unstable = 1'b0;
      end
      prev_st = stall_w;
    end
  end

  task automatic expect_txn(input int g, input int stall_n, input int req_n, input logic we,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd_exp, input logic err);
    exp_t e;
    e.stall_n = stall_n;
    e.req_n   = req_n;
    e.we      = we;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = rd_exp;
    e.err     = err;
    exp_q[g].push_back(e);
  endtask

  // Issue one access from IDLE (called at posedge+1). ack_at = WAIT cycle
  // number carrying the ack (0 = never). Returns at posedge+1 of the IDLE
  // cycle following DONE.
  task automatic access(input int g, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] ad, input logic stray_done);
    logic done_seen;
    done_seen = 1'b0;
    rd[g] = r; wr[g] = w; addr[g] = a; wdata[g] = d;
    @(posedge clk); #1;
    rd[g] = 1'b0; wr[g] = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (!stall_v[g]) begin
        done_seen = 1'b1;
        break;
      end
      ack[g]    = (k == ack_at);
      brdata[g] = (k == ack_at) ? ad : (32'hBAD0_0000 | 32'(k));
      @(posedge clk); #1;
    end
    chk($sformatf("dut%0d access_completes", g), {31'd0, done_seen}, 32'd1);
    ack[g]    = stray_done;
    brdata[g] = 32'h5555_AAAA;
    @(posedge clk); #1;
    ack[g] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      ack[i] = 1'b0; brdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d reset stall", i), {31'd0, stall_v[i]}, 32'd0);
      chk($sformatf("dut%0d reset err", i), {31'd0, err_v[i]}, 32'd0);
      chk($sformatf("dut%0d reset req", i), {31'd0, req_v[i]}, 32'd0);
      chk($sformatf("dut%0d reset we", i), {31'd0, we_v[i]}, 32'd0);
      chk($sformatf("dut%0d reset rdata", i), rdata_a[i], 32'd0);
      chk($sformatf("dut%0d reset addr", i), baddr_a[i], 32'd0);
      chk($sformatf("dut%0d reset wdata", i), bwdata_a[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Read, ack in first WAIT cycle.
    expect_txn(0, 2, 1, 1'b0, 32'h0000_0010, 32'h0, 32'h8C01_0004, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h8C01_0004, 1'b0);

    // Write, ack in fifth WAIT cycle; ack data must not reach rdata_o.
    expect_txn(0, 6, 5, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h8C01_0004, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5, 32'hDEAD_BEEF, 1'b0);

    // Misaligned read: no request, error from DONE onward.
    expect_txn(0, 1, 0, 1'b0, 32'h0, 32'h0, 32'h8C01_0004, 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b0);

    // Read and write together: write wins; stray ack held into DONE.
    expect_txn(0, 2, 1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'h8C01_0004, 1'b1);
    access(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'hFFFF_0000, 1'b1);

    // Stray ack pulses in IDLE.
    ack[0] = 1'b1; brdata[0] = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    ack[0] = 1'b0;
    chk("dut0 stray_ack stall", {31'd0, stall_v[0]}, 32'd0);
    chk("dut0 stray_ack req", {31'd0, req_v[0]}, 32'd0);
    chk("dut0 stray_ack rdata", rdata_a[0], 32'h8C01_0004);

    // Timeout instance: no ack, TIMEOUT = 4.
    expect_txn(1, 5, 4, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1);
    access(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0);
    // Good read afterwards, error stays set.
    expect_txn(1, 2, 1, 1'b0, 32'h0000_0104, 32'h0, 32'h1111_2222, 1'b1);
    access(1, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'h1111_2222, 1'b0);
    // Ack in the very cycle the timeout would fire: ack wins.
    expect_txn(1, 5, 4, 1'b1, 32'h0000_0108, 32'h0BAD_CAFE, 32'h1111_2222, 1'b1);
    access(1, 1'b0, 1'b1, 32'h0000_0108, 32'h0BAD_CAFE, 4, 32'h9999_9999, 1'b0);

    // Reset during the third WAIT cycle of a read.
    expect_txn(0, 3, 2, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 1'b0);
    rd[0] = 1'b1; addr[0] = 32'h0000_0050; wdata[0] = 32'h0;
    @(posedge clk); #1;
    rd[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("dut0 midrst stall", {31'd0, stall_v[0]}, 32'd0);
    chk("dut0 midrst req", {31'd0, req_v[0]}, 32'd0);
    chk("dut0 midrst err", {31'd0, err_v[0]}, 32'd0);
    chk("dut0 midrst rdata", rdata_a[0], 32'd0);
    chk("dut0 midrst addr", baddr_a[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack[0] = 1'b1; brdata[0] = 32'h6666_6666;
    @(posedge clk); #1;
    ack[0] = 1'b0;
    chk("dut0 late_ack stall", {31'd0, stall_v[0]}, 32'd0);
    chk("dut0 late_ack rdata", rdata_a[0], 32'd0);

    // Normal read after reset, ack in second WAIT cycle.
    expect_txn(0, 3, 2, 1'b0, 32'h0000_0054, 32'h0, 32'hA5A5_0001, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0054, 32'h0, 2, 32'hA5A5_0001, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("dut0 queue_drained", 32'(exp_q[0].size()), 32'd0);
    chk("dut1 queue_drained", 32'(exp_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
